// File: rtl/iz_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : iz_pkg                                                      |
// | Description: Shared constants and types for the Izhikevich scheduler.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package iz_pkg;

  localparam int SCALE = 64;
  localparam logic signed [15:0] V_REST   = -16'sd4480;
  localparam logic signed [15:0] V_THRESH = 16'sd1920;

  // Q.6 membrane / recovery state word
  typedef logic signed [15:0] iz_val_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } iz_fsm_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iz_event_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : iz_event_fifo                                               |
// | Description: First-word-fall-through spike event FIFO with sticky        |
// |              overflow flag; DEPTH must be a power of two, at least 2.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module iz_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_overflow;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  // Pointers differ only in the wrap bit when the FIFO is full
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!w_full || w_do_pop);
  assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (push && !w_do_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/iz_neuron_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : iz_neuron_scheduler                                         |
// | Description: Sweeps NUM_NEURONS virtual neurons through one shared       |
// |              update datapath and queues spike events. Define             |
// |              IZ_SCHED_TIMEOUT_EN to add the dp_ack watchdog.             |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module iz_neuron_scheduler
  import iz_pkg::*;
#(
  parameter  int NUM_NEURONS = 8,
  parameter  int EVT_DEPTH   = 4,
  localparam int IDX_W       = idx_width(NUM_NEURONS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  output logic                    busy,
  output logic                    dp_req,
  output logic [IDX_W-1:0]        dp_idx,
  output logic signed [15:0]      dp_v,
  output logic signed [15:0]      dp_u,
  input  logic                    dp_ack,
  input  logic [15:0]             dp_v_next,
  input  logic [15:0]             dp_u_next,
  input  logic                    dp_spike,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [IDX_W-1:0]        evt_idx,
  output logic                    sweep_done,
  output logic                    evt_overflow,
`ifdef IZ_SCHED_TIMEOUT_EN
  output logic                    dp_timeout,
`endif
  output logic                    tick_overrun
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_NEURONS - 1);

  iz_fsm_t          r_state;
  logic [IDX_W-1:0] r_idx;
  iz_val_t          r_v [NUM_NEURONS];
  iz_val_t          r_u [NUM_NEURONS];
  iz_val_t          r_cap_v;
  iz_val_t          r_cap_u;
  logic             r_cap_spike;
  logic             r_busy;
  logic             r_dp_req;
  logic             r_sweep_done;
  logic             r_tick_overrun;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;

`ifdef IZ_SCHED_TIMEOUT_EN
  logic [7:0]       r_wd;
  logic             r_dp_timeout;
  logic [7:0]       w_wd_next;

  assign w_wd_next  = r_wd + 8'd1;
  assign dp_timeout = r_dp_timeout;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_cap_v        <= '0;
      r_cap_u        <= '0;
      r_cap_spike    <= 1'b0;
      r_busy         <= 1'b0;
      r_dp_req       <= 1'b0;
      r_sweep_done   <= 1'b0;
      r_tick_overrun <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_v[i] <= V_REST;
        r_u[i] <= '0;
      end
`ifdef IZ_SCHED_TIMEOUT_EN
      r_wd           <= '0;
      r_dp_timeout   <= 1'b0;
`endif
    end else begin
      if (tick && (r_state != ST_IDLE)) r_tick_overrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (tick) begin
            r_state  <= ST_ISSUE;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_dp_req <= 1'b1;
`ifdef IZ_SCHED_TIMEOUT_EN
            r_wd     <= '0;
`endif
          end
        end

        ST_ISSUE: begin
          if (dp_ack) begin
            r_cap_v     <= dp_v_next;
            r_cap_u     <= dp_u_next;
            r_cap_spike <= dp_spike;
            r_dp_req    <= 1'b0;
            r_state     <= ST_WRITE;
          end
`ifdef IZ_SCHED_TIMEOUT_EN
          // Stalled datapath: drop this neuron and move on as if written
          else if (w_wd_next == 8'hFF) begin
            r_dp_timeout <= 1'b1;
            r_wd         <= '0;
            if (r_idx == c_last_idx) begin
              r_state      <= ST_DONE;
              r_dp_req     <= 1'b0;
              r_sweep_done <= 1'b1;
            end else begin
              r_idx        <= r_idx + IDX_W'(1);
            end
          end else begin
            r_wd <= w_wd_next;
          end
`endif
        end

        ST_WRITE: begin
          r_v[r_idx] <= r_cap_v;
          r_u[r_idx] <= r_cap_u;
          if (r_idx == c_last_idx) begin
            r_state      <= ST_DONE;
            r_sweep_done <= 1'b1;
          end else begin
            r_idx    <= r_idx + IDX_W'(1);
            r_state  <= ST_ISSUE;
            r_dp_req <= 1'b1;
`ifdef IZ_SCHED_TIMEOUT_EN
            r_wd     <= '0;
`endif
          end
        end

        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_sweep_done <= 1'b0;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_dp_req <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign dp_req       = r_dp_req;
  assign dp_idx       = r_idx;
  assign dp_v         = r_v[r_idx];
  assign dp_u         = r_u[r_idx];
  assign sweep_done   = r_sweep_done;
  assign tick_overrun = r_tick_overrun;

  assign w_push    = (r_state == ST_WRITE) && r_cap_spike;
  assign w_pop     = evt_valid && evt_ready;
  assign evt_valid = !w_empty;

  iz_event_fifo #(
    .DEPTH (EVT_DEPTH),
    .WIDTH (IDX_W)
  ) u_event_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (r_idx),
    .pop       (w_pop),
    .pop_data  (evt_idx),
    .empty     (w_empty),
    .overflow  (evt_overflow)
  );

endmodule
`default_nettype wire

// File: tb/tb_iz_neuron_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_iz_neuron_scheduler                                      |
// | Description: Directed self-checking bench for iz_neuron_scheduler.       |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_iz_neuron_scheduler;
  import iz_pkg::*;

  localparam int N = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              tick;
  logic              busy;
  logic              dp_req;
  logic [2:0]        dp_idx;
  logic signed [15:0] dp_v;
  logic signed [15:0] dp_u;
  logic              dp_ack;
  logic [15:0]       dp_v_next;
  logic [15:0]       dp_u_next;
  logic              dp_spike;
  logic              evt_valid;
  logic              evt_ready;
  logic [2:0]        evt_idx;
  logic              sweep_done;
  logic              evt_overflow;
  logic              tick_overrun;
`ifdef IZ_SCHED_TIMEOUT_EN
  logic              dp_timeout;
`endif

  iz_neuron_scheduler #(.NUM_NEURONS(N), .EVT_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .busy         (busy),
    .dp_req       (dp_req),
    .dp_idx       (dp_idx),
    .dp_v         (dp_v),
    .dp_u         (dp_u),
    .dp_ack       (dp_ack),
    .dp_v_next    (dp_v_next),
    .dp_u_next    (dp_u_next),
    .dp_spike     (dp_spike),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_idx      (evt_idx),
    .sweep_done   (sweep_done),
    .evt_overflow (evt_overflow),
`ifdef IZ_SCHED_TIMEOUT_EN
    .dp_timeout   (dp_timeout),
`endif
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [15:0] mv [N];
  logic signed [15:0] mu [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = V_REST;
      mu[i] = 16'sd0;
    end
  endtask

  // One sweep against a reference datapath: v' = v + 100 + i, u' = u + 3 - i.
  task automatic run_sweep(input int dly_idx, input int dly, input logic [7:0] spk,
                           input int retick, input int rst_idx, input int na_idx,
                           output int done_cyc, output int dones, output int issue_n);
    int cyc, exp_idx, waited;
    bit stop;
    logic [15:0] vn, un;
    done_cyc = 0; dones = 0; issue_n = 0;
    exp_idx = 0; waited = 0; stop = 0; cyc = 1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    while (!stop) begin
      dp_ack   = 1'b0;
      dp_spike = 1'b0;
      tick     = (cyc == retick);
      if (dp_req && exp_idx == na_idx && exp_idx < N && dp_idx != exp_idx[2:0]) begin
        check("wd_cycles", waited, 255);
`ifdef IZ_SCHED_TIMEOUT_EN
        check("dp_timeout", dp_timeout, 1);
`endif
        exp_idx++;
        waited = 0;
      end
      if (dp_req && exp_idx >= N) begin
        check("req_after_last", dp_req, 0);
        stop = 1;
      end else if (dp_req) begin
        if (waited == 0 || exp_idx == dly_idx) begin
          check($sformatf("dp_idx@%0d", exp_idx), dp_idx, exp_idx);
          check($sformatf("dp_v[%0d]", exp_idx), dp_v, mv[exp_idx]);
          check($sformatf("dp_u[%0d]", exp_idx), dp_u, mu[exp_idx]);
        end
        if (exp_idx == dly_idx) issue_n++;
        if (exp_idx == rst_idx) begin
          check("evt_valid_pre_rst", evt_valid, 1);
          reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0;
          model_reset();
          stop = 1;
        end else if (exp_idx != na_idx && waited == ((exp_idx == dly_idx) ? dly : 0)) begin
          vn = mv[exp_idx] + 16'd100 + 16'(exp_idx);
          un = mu[exp_idx] + 16'd3 - 16'(exp_idx);
          dp_ack    = 1'b1;
          dp_v_next = vn;
          dp_u_next = un;
          dp_spike  = spk[exp_idx];
          mv[exp_idx] = vn;
          mu[exp_idx] = un;
          exp_idx++;
          waited = 0;
        end else begin
          waited++;
        end
      end
      if (sweep_done) begin
        dones++;
        done_cyc = cyc;
      end
      if (!stop) begin
        if (dones > 0 && !busy && !sweep_done) stop = 1;
        else if (cyc >= 700) begin
          check("sweep_budget_busy", busy, 0);
          stop = 1;
        end else begin
          @(posedge clk); #1;
          cyc++;
        end
      end
    end
    dp_ack   = 1'b0;
    dp_spike = 1'b0;
    tick     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc, dn, isn, extra;
    logic [2:0] ev [4];
    ev[0] = 3'd1; ev[1] = 3'd3; ev[2] = 3'd5; ev[3] = 3'd6;
    reset = 1'b1; tick = 1'b0; dp_ack = 1'b0; dp_spike = 1'b0;
    dp_v_next = '0; dp_u_next = '0; evt_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_dp_req", dp_req, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_evt_overflow", evt_overflow, 0);
    check("rst_tick_overrun", tick_overrun, 0);
`ifdef IZ_SCHED_TIMEOUT_EN
    check("rst_dp_timeout", dp_timeout, 0);
`endif

    // Immediate ack: DONE lands 2*N+1 cycles after the tick-capture cycle
    run_sweep(-1, 0, 8'h00, 0, -1, -1, dc, dn, isn);
    check("A_done_cycle", dc, 17);
    check("A_done_count", dn, 1);
    check("A_evt_valid", evt_valid, 0);

    // Delayed ack on idx 2, spikes on 1,3,5,6,7 into a depth-4 FIFO
    run_sweep(2, 3, 8'hEA, 0, -1, -1, dc, dn, isn);
    check("B_done_cycle", dc, 20);
    check("B_issue_cycles_idx2", isn, 4);
    check("B_evt_overflow", evt_overflow, 1);
    check("B_tick_overrun", tick_overrun, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("B_pop%0d_valid", k), evt_valid, 1);
      check($sformatf("B_pop%0d_idx", k), evt_idx, ev[k]);
      evt_ready = 1'b1;
      @(posedge clk); #1;
      evt_ready = 1'b0;
    end
    check("B_fifo_empty", evt_valid, 0);
    check("B_overflow_sticky", evt_overflow, 1);

    // Tick during a sweep is ignored but flagged
    run_sweep(-1, 0, 8'h00, 5, -1, -1, dc, dn, isn);
    check("C_done_cycle", dc, 17);
    check("C_done_count", dn, 1);
    check("C_tick_overrun", tick_overrun, 1);
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (sweep_done || busy) extra++;
    end
    check("C_no_second_sweep", extra, 0);

    // Reset in ISSUE of idx 4 with events queued
    run_sweep(-1, 0, 8'h0F, 0, 4, -1, dc, dn, isn);
    check("D_busy", busy, 0);
    check("D_dp_req", dp_req, 0);
    check("D_evt_valid", evt_valid, 0);
    check("D_evt_overflow", evt_overflow, 0);
    check("D_tick_overrun", tick_overrun, 0);
    check("D_done_count", dn, 0);

    // Ack while idle must not write anything or queue events
    dp_ack = 1'b1; dp_v_next = 16'h1234; dp_u_next = 16'h0055; dp_spike = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dp_ack = 1'b0; dp_spike = 1'b0;
    check("idle_ack_evt_valid", evt_valid, 0);
    check("idle_ack_busy", busy, 0);

    // All v back at rest (16'hEE80) after the mid-sweep reset
    run_sweep(-1, 0, 8'h00, 0, -1, -1, dc, dn, isn);
    check("E_done_cycle", dc, 17);
    check("E_done_count", dn, 1);

`ifdef IZ_SCHED_TIMEOUT_EN
    run_sweep(-1, 0, 8'h00, 0, -1, 0, dc, dn, isn);
    check("T_done_count", dn, 1);
    check("T_dp_timeout_sticky", dp_timeout, 1);
    run_sweep(-1, 0, 8'h00, 0, -1, -1, dc, dn, isn);
    check("T_followup_done", dn, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
